// File: rtl/vid_timing_gen.sv
// vid_timing_gen: one axis (line or frame) of the video timing path.
// A one-hot phase FSM (IDLE -> SYNC -> GDEL -> GATE -> LEN) walks each period.
// The phase down-counter (cnt) times the individual phases. The period
// down-counter (cnt_len) times the whole period. When cnt_len reaches zero it
// forces a restart in SYNC, even if a phase is still running.
// Sync, Gate and Done are registered. state, cnt and cnt_len are exported for
// the downstream output-decode stage.
module vid_timing_gen #(
   parameter int SW = 8,
   parameter int LW = 16
) (
   input  logic          clk,
   input  logic          nReset,
   input  logic          rst,
   input  logic          ena,
   input  logic [SW-1:0] Tsync,
   input  logic [SW-1:0] Tgdel,
   input  logic [LW-1:0] Tgate,
   input  logic [LW-1:0] Tlen,
   output logic          Sync,
   output logic          Gate,
   output logic          Done,
   output logic [4:0]    state,
   output logic [LW-1:0] cnt,
   output logic [LW-1:0] cnt_len
);

   localparam logic [4:0] ST_IDLE = 5'b00001;
   localparam logic [4:0] ST_SYNC = 5'b00010;
   localparam logic [4:0] ST_GDEL = 5'b00100;
   localparam logic [4:0] ST_GATE = 5'b01000;
   localparam logic [4:0] ST_LEN  = 5'b10000;

   logic [4:0]    state_next;
   logic [LW-1:0] cnt_next;
   logic [LW-1:0] cnt_len_next;
   logic          sync_next;
   logic          gate_next;
   logic          done_next;
   logic          period_end;

   // The period counter expiring outside IDLE ends the period.
   // This overrides any phase transition on the same edge.
   assign period_end = (state != ST_IDLE) && (cnt_len == '0);

   // State and counter registers.
   // Done is a one-cycle strobe, so it drops on any edge that does not load it.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         cnt_len <= '0;
         Sync    <= 1'b0;
         Gate    <= 1'b0;
         Done    <= 1'b0;
      end else if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         cnt_len <= '0;
         Sync    <= 1'b0;
         Gate    <= 1'b0;
         Done    <= 1'b0;
      end else if (ena) begin
         state   <= state_next;
         cnt     <= cnt_next;
         cnt_len <= cnt_len_next;
         Sync    <= sync_next;
         Gate    <= gate_next;
         Done    <= done_next;
      end else begin
         Done    <= 1'b0;
      end
   end

   // Next-state and counter logic.
   // The T* inputs are sampled only on the edge that loads them.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      cnt_len_next = cnt_len;
      if (state == ST_IDLE || period_end) begin
         state_next   = ST_SYNC;
         cnt_next     = LW'(Tsync);
         cnt_len_next = Tlen;
      end else begin
         cnt_len_next = cnt_len - LW'(1);
         case (state)
            ST_SYNC: begin
               if (cnt != '0) begin
                  cnt_next = cnt - LW'(1);
               end else begin
                  state_next = ST_GDEL;
                  cnt_next   = LW'(Tgdel);
               end
            end
            ST_GDEL: begin
               if (cnt != '0) begin
                  cnt_next = cnt - LW'(1);
               end else begin
                  state_next = ST_GATE;
                  cnt_next   = Tgate;
               end
            end
            ST_GATE: begin
               if (cnt != '0) begin
                  cnt_next = cnt - LW'(1);
               end else begin
                  state_next = ST_LEN;
               end
            end
            ST_LEN: begin
               state_next = ST_LEN;
            end
            default: begin
               // A non-one-hot code is unreachable.
               // Fall back to IDLE so the axis restarts cleanly.
               state_next   = ST_IDLE;
               cnt_next     = '0;
               cnt_len_next = '0;
            end
         endcase
      end
   end

   // Output decode.
   // Sync and Gate follow the phase being entered.
   // Done marks the first cycle of every new period, but not the first period.
   always_comb begin
      sync_next = (state_next == ST_SYNC);
      gate_next = (state_next == ST_GATE);
      done_next = period_end;
   end

endmodule
